// File: rtl/clkgen_nco_pkg.sv
// Shared constants for the NCO clock generator: default widths and clock
// rate, the pending-step state encoding, and the PPS counter width helper.
package clkgen_nco_pkg;

   localparam int BUSW_DEFAULT         = 32;
   localparam int CLOCKFREQ_HZ_DEFAULT = 100_000_000;

   // Step-update controller: either no step is waiting, or one is waiting
   // for the next phase wrap (or for the next cycle when stopped).
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } step_state_t;

   // Width of a counter that must hold values 0 .. hz.
   function automatic int pps_cnt_w(input int hz);
      return $clog2(hz + 1);
   endfunction

endpackage

// File: rtl/clkgen_nco_if.sv
// Step-programming and clock-output bundle for the NCO clock generator.
//
// Handshake: wr is a single-cycle strobe with no ready; a write is always
// accepted and step is sampled on the same edge. busy stays high while the
// written step waits for the next phase wrap; a further write during busy
// simply replaces the waiting value. cur_step is the step in use, nco_clk the
// generated clock, stb its rising-edge strobe and pps the once-per-second tick.
interface clkgen_nco_if
   import clkgen_nco_pkg::*;
#(
   parameter int BUSW = BUSW_DEFAULT
);

   logic            wr;
   logic [BUSW-1:0] step;
   logic            busy;
   logic [BUSW-1:0] cur_step;
   logic            nco_clk;
   logic            stb;
   logic            pps;

   modport master (
      output wr, step,
      input  busy, cur_step, nco_clk, stb, pps
   );

   modport slave (
      input  wr, step,
      output busy, cur_step, nco_clk, stb, pps
   );

endinterface

// File: rtl/clkgen_nco_ppsgen.sv
// Once-per-second tick: a free-running 0 .. CLOCKFREQ_HZ-1 counter whose
// terminal count produces a registered one-cycle pulse on the next cycle.
module ppsgen
   import clkgen_nco_pkg::*;
#(
   parameter int CLOCKFREQ_HZ = CLOCKFREQ_HZ_DEFAULT
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_pps
);

   localparam int CW = pps_cnt_w(CLOCKFREQ_HZ);
   localparam logic [CW-1:0] LAST = CW'(CLOCKFREQ_HZ - 1);

   logic [CW-1:0] cnt;

   // Count cycles since reset release and flag the wrap one cycle later.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt   <= '0;
         o_pps <= 1'b0;
      end else begin
         o_pps <= (cnt == LAST);
         cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/clkgen_nco.sv
// Numerically controlled oscillator producing a test clock from the MSB of a
// phase accumulator. New step words are held pending and applied only at a
// phase wrap so the output never produces a runt high or low phase; when the
// oscillator is stopped the pending step goes in on the next cycle instead.
module clkgen_nco
   import clkgen_nco_pkg::*;
#(
   parameter int              BUSW         = BUSW_DEFAULT,
   parameter int              CLOCKFREQ_HZ = CLOCKFREQ_HZ_DEFAULT,
   parameter logic [BUSW-1:0] DEFAULT_STEP = '0
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_wr,
   input  logic [BUSW-1:0] i_step,
   output logic            o_busy,
   output logic [BUSW-1:0] o_step,
   output logic            o_clk,
   output logic            o_stb,
   output logic            o_pps
);

   logic [BUSW-1:0] phase;
   logic [BUSW-1:0] pending;
   logic            prev_msb;
   logic [BUSW:0]   sum;
   logic            carry;
   logic            apply;
   step_state_t     state;
   step_state_t     state_nxt;

   // Accumulator add with the carry kept only to detect a phase wrap.
   assign sum   = {1'b0, phase} + {1'b0, o_step};
   assign carry = sum[BUSW];

   // Step-controller state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Decide when the waiting step goes in; a write landing on the apply
   // cycle keeps the controller pending with the newer value.
   always_comb begin
      state_nxt = state;
      apply     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_wr) begin
               state_nxt = ST_PENDING;
            end
         end
         ST_PENDING: begin
            apply = carry || (o_step == '0);
            if (apply && !i_wr) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Phase accumulation, step capture and step application; the phase is
   // never cleared by an update so the output stays continuous.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         phase    <= '0;
         prev_msb <= 1'b0;
         pending  <= '0;
         o_step   <= DEFAULT_STEP;
      end else begin
         phase    <= sum[BUSW-1:0];
         prev_msb <= phase[BUSW-1];
         if (i_wr) begin
            pending <= i_step;
         end
         if (apply) begin
            o_step <= pending;
         end
      end
   end

   assign o_busy = (state == ST_PENDING);
   assign o_clk  = phase[BUSW-1];
   assign o_stb  = phase[BUSW-1] & ~prev_msb;

   ppsgen #(
      .CLOCKFREQ_HZ (CLOCKFREQ_HZ)
   ) u_ppsgen (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_pps   (o_pps)
   );

endmodule

// File: tb/tb_clkgen_nco.sv
// Bench for clkgen_nco with a 32-bit accumulator and a 10-cycle PPS period.
// An arithmetic model predicts every output each cycle into an expected
// queue; directed scenarios add hand-computed literal expectations.
module tb_clkgen_nco;

   localparam int BUSW = 32;
   localparam int HZ   = 10;
   localparam logic [31:0] DEF_STEP = 32'h0000_0000;
   localparam longint FULL = 64'h1_0000_0000;
   localparam longint HALF = 64'h0_8000_0000;
   localparam int W = 36;

   logic clk;
   logic rst;

   clkgen_nco_if #(.BUSW(BUSW)) bus ();

   clkgen_nco #(
      .BUSW         (BUSW),
      .CLOCKFREQ_HZ (HZ),
      .DEFAULT_STEP (DEF_STEP)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_wr    (bus.wr),
      .i_step  (bus.step),
      .o_busy  (bus.busy),
      .o_step  (bus.cur_step),
      .o_clk   (bus.nco_clk),
      .o_stb   (bus.stb),
      .o_pps   (bus.pps)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   // Phase is plain modular arithmetic; the clock is "phase in the upper
   // half"; a waiting step goes in after a wrap or when stopped; PPS fires
   // every HZ cycles counted from the first cycle after reset.
   longint m_phase, m_step, m_pend, m_sum;
   logic   m_pend_v;
   logic   m_prev_clk;
   logic   e_clk;
   int     m_since;
   logic [W-1:0] exp_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_phase    = 0;
         m_prev_clk = 1'b0;
         m_step     = longint'(DEF_STEP);
         m_pend     = 0;
         m_pend_v   = 1'b0;
         m_since    = 0;
      end else begin
         m_sum      = m_phase + m_step;
         m_prev_clk = (m_phase >= HALF);
         m_phase    = m_sum % FULL;
         if (m_pend_v && (m_sum >= FULL || m_step == 0)) begin
            m_step   = m_pend;
            m_pend_v = 1'b0;
         end
         if (bus.wr) begin
            m_pend   = longint'(bus.step);
            m_pend_v = 1'b1;
         end
         m_since++;
      end
      e_clk = (m_phase >= HALF);
      exp_q.push_back({m_step[31:0], m_pend_v, e_clk, e_clk && !m_prev_clk,
                       (m_since != 0) && (m_since % HZ == 0)});
   end

   // ---------------- scoreboard compare ----------------
   logic [W-1:0] exp_v;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         check("sb_step", bus.cur_step, exp_v[35:4]);
         check("sb_busy", bus.busy,     exp_v[3]);
         check("sb_clk",  bus.nco_clk,  exp_v[2]);
         check("sb_stb",  bus.stb,      exp_v[1]);
         check("sb_pps",  bus.pps,      exp_v[0]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      while (bus.busy && n < bound) begin
         tick();
         n++;
      end
      check(name, bus.busy, 0);
   endtask

   task automatic measure(output int period, output int highs);
      int n = 0;
      while (!bus.stb && n < 20) begin
         tick();
         n++;
      end
      check("stb_seen", bus.stb, 1);
      period = 0;
      highs  = 0;
      do begin
         tick();
         period++;
         if (bus.nco_clk) highs++;
      end while (!bus.stb && period < 20);
   endtask

   logic s1_clk [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic s1_stb [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   // ---------------- directed stimulus ----------------
   initial begin
      int period, highs, toggles, stbs, n;
      logic last_clk;

      rst      = 1'b1;
      bus.wr   = 1'b0;
      bus.step = '0;
      repeat (2) tick();

      // A write during reset must be ignored.
      bus.wr   = 1'b1;
      bus.step = 32'hDEAD_BEEF;
      tick();
      bus.wr   = 1'b0;
      tick();
      check("rst_busy", bus.busy, 0);
      check("rst_step", bus.cur_step, 32'h0);
      check("rst_clk",  bus.nco_clk, 0);
      check("rst_stb",  bus.stb, 0);
      check("rst_pps",  bus.pps, 0);

      rst = 1'b0;
      tick();

      // Start from stopped at a quarter-rate step.
      bus.wr   = 1'b1;
      bus.step = 32'h4000_0000;
      tick();
      bus.wr   = 1'b0;
      check("s1_busy_set", bus.busy, 1);
      check("s1_step_old", bus.cur_step, 32'h0);
      tick();
      check("s1_busy_clr", bus.busy, 0);
      check("s1_step_new", bus.cur_step, 32'h4000_0000);
      check("s1_clk0",     bus.nco_clk, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("s1_clk", bus.nco_clk, s1_clk[i]);
         check("s1_stb", bus.stb, s1_stb[i]);
      end

      // Mid-period change to an eighth-rate step.
      repeat (2) tick();
      check("s2_mid_clk", bus.nco_clk, 1);
      bus.wr   = 1'b1;
      bus.step = 32'h2000_0000;
      tick();
      bus.wr   = 1'b0;
      check("s2_busy", bus.busy, 1);
      check("s2_step_hold", bus.cur_step, 32'h4000_0000);
      wait_idle(16, "s2_idle_timeout");
      check("s2_step_new", bus.cur_step, 32'h2000_0000);
      measure(period, highs);
      check("s2_period", period, 8);
      check("s2_high", highs, 4);

      // Two writes while busy: only the last is applied.
      bus.wr   = 1'b1;
      bus.step = 32'h1000_0000;
      tick();
      bus.step = 32'h0800_0000;
      tick();
      bus.wr   = 1'b0;
      check("s3_busy", bus.busy, 1);
      wait_idle(16, "s3_idle_timeout");
      check("s3_step_new", bus.cur_step, 32'h0800_0000);

      // Half-rate step: toggles every cycle.
      bus.wr   = 1'b1;
      bus.step = 32'h8000_0000;
      tick();
      bus.wr   = 1'b0;
      wait_idle(80, "s4_idle_timeout");
      check("s4_step_new", bus.cur_step, 32'h8000_0000);
      toggles  = 0;
      stbs     = 0;
      last_clk = bus.nco_clk;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.nco_clk != last_clk) toggles++;
         if (bus.stb) stbs++;
         last_clk = bus.nco_clk;
      end
      check("s4_toggles", toggles, 8);
      check("s4_stbs", stbs, 4);

      // Write landing on the same cycle a wrap applies the older value.
      n = 0;
      while (bus.nco_clk && n < 4) begin
         tick();
         n++;
      end
      check("s5_clk_low", bus.nco_clk, 0);
      bus.wr   = 1'b1;
      bus.step = 32'h4000_0000;
      tick();
      check("s5_busy1", bus.busy, 1);
      bus.step = 32'h2000_0000;
      tick();
      bus.wr   = 1'b0;
      check("s5_step_mid", bus.cur_step, 32'h4000_0000);
      check("s5_busy2", bus.busy, 1);
      wait_idle(16, "s5_idle_timeout");
      check("s5_step_new", bus.cur_step, 32'h2000_0000);

      // Reset while a step is pending.
      bus.wr   = 1'b1;
      bus.step = 32'h0100_0000;
      tick();
      bus.wr   = 1'b0;
      check("s6_busy", bus.busy, 1);
      rst = 1'b1;
      tick();
      check("s6_busy_rst", bus.busy, 0);
      check("s6_step_rst", bus.cur_step, 32'h0);
      check("s6_clk_rst",  bus.nco_clk, 0);

      // PPS cadence from release, then restart by a reset pulse at cycle 15.
      rst = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         check("s7_pps", bus.pps, (k % 10) == 0);
      end
      check("s7_step_kept", bus.cur_step, 32'h0);
      check("s7_busy_kept", bus.busy, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         check("s8_pps_a", bus.pps, k == 10);
      end
      rst = 1'b1;
      tick();
      check("s8_pps_rst", bus.pps, 0);
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check("s8_pps_b", bus.pps, k == 10);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
